// File: rtl/fsmc_read_slave.sv
// FSMC read-path responder: synchronises the async STM32 bus strobes, fetches one word per read
// strobe from a register source over a req/ack handshake and drives it onto the pads while NOE is low.
// Latency aNOE fall -> d_oe: 2 sync + 1 + ack wait + 1 clk; d_oe release 3 clk after aNOE rise.
// Backpressure: rd_req is a level held until rd_ack (never withdrawn); bus side cannot be stalled.
//
// Ports: clk/rst (async active-high); aNE/aNOE/aNWE/aA async FSMC inputs; d_out/d_oe pad drive;
// rd_req/rd_adr/rd_ack/rd_data register-source handshake; rd_count completed driven reads (mod 256);
// rd_err sticky timeout flag.
// Optional macro FSMC_READ_TIMEOUT_EN: bounds the wait for rd_ack to TIMEOUT REQ cycles and returns
// TIMEOUT_DATA with rd_err set; without it REQ waits indefinitely and rd_err is tied 0.
module fsmc_read_slave #(
  parameter int              AW           = 2,
  parameter int              DW           = 16,
  parameter int              TIMEOUT      = 15,
  parameter logic [DW-1:0]   TIMEOUT_DATA = 16'hDEAD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aNE,
  input  logic          aNOE,
  input  logic          aNWE,
  input  logic [AW-1:0] aA,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  output logic          rd_req,
  output logic [AW-1:0] rd_adr,
  input  logic          rd_ack,
  input  logic [DW-1:0] rd_data,
  output logic [7:0]    rd_count,
  output logic          rd_err
);

  typedef enum logic [1:0] {IDLE, REQ, DRIVE, ABORT} state_t;

  // Two-flop synchronisers; strobes reset to their inactive (high) level.
  logic [1:0]    ne_sy, noe_sy, nwe_sy;
  logic [AW-1:0] a_sy1, a_sy2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ne_sy  <= 2'b11;
      noe_sy <= 2'b11;
      nwe_sy <= 2'b11;
      a_sy1  <= '0;
      a_sy2  <= '0;
    end else begin
      ne_sy  <= {ne_sy[0], aNE};
      noe_sy <= {noe_sy[0], aNOE};
      nwe_sy <= {nwe_sy[0], aNWE};
      a_sy1  <= aA;
      a_sy2  <= a_sy1;
    end
  end

  logic s_ne, s_noe, s_nwe, rdc;
  assign s_ne  = ne_sy[1];
  assign s_noe = noe_sy[1];
  assign s_nwe = nwe_sy[1];
  assign rdc   = ~s_ne & ~s_noe & s_nwe;

  state_t        state_q, state_nxt;
  logic          req_q, req_nxt;
  logic [AW-1:0] adr_q, adr_nxt;
  logic [DW-1:0] dout_q, dout_nxt;
  logic          doe_q, doe_nxt;
  logic [7:0]    cnt_q, cnt_nxt;
  logic          err_q, err_nxt;
  logic          fetch_done;
  logic [DW-1:0] fetch_data;

`ifdef FSMC_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_nxt, tmo_inc;
  assign tmo_inc = tmo_q + 1'b1;
`else
  logic unused_params;
  assign unused_params = ^{TIMEOUT_DATA, 32'(TIMEOUT)};
`endif

  always_comb begin
    state_nxt  = state_q;
    req_nxt    = req_q;
    adr_nxt    = adr_q;
    dout_nxt   = dout_q;
    doe_nxt    = doe_q;
    cnt_nxt    = cnt_q;
    err_nxt    = err_q;
    fetch_done = rd_ack;
    fetch_data = rd_data;
`ifdef FSMC_READ_TIMEOUT_EN
    tmo_nxt    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (rdc) begin
          adr_nxt   = a_sy2;
          req_nxt   = 1'b1;
          state_nxt = REQ;
`ifdef FSMC_READ_TIMEOUT_EN
          tmo_nxt   = '0;
`endif
        end
      end
      REQ: begin
`ifdef FSMC_READ_TIMEOUT_EN
        // A missing ack is replaced by the timeout word so the bus cycle still completes.
        if (!rd_ack) begin
          if (tmo_inc == TW'(TIMEOUT)) begin
            fetch_done = 1'b1;
            fetch_data = TIMEOUT_DATA;
            err_nxt    = 1'b1;
          end else begin
            tmo_nxt    = tmo_inc;
          end
        end
`endif
        // Handshake is completed even if the strobe has already gone; data is then dropped.
        if (fetch_done) begin
          req_nxt  = 1'b0;
          dout_nxt = fetch_data;
          if (rdc) begin
            doe_nxt   = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = ABORT;
          end
        end
      end
      DRIVE: begin
        // A falling NWE is treated as the end of the read cycle as well.
        if (s_noe || s_ne || !s_nwe) begin
          doe_nxt   = 1'b0;
          cnt_nxt   = cnt_q + 8'd1;
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        // Hold off until the strobe is gone so a long NOE yields only one request.
        if (!rdc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef FSMC_READ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      req_q   <= req_nxt;
      adr_q   <= adr_nxt;
      dout_q  <= dout_nxt;
      doe_q   <= doe_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
`ifdef FSMC_READ_TIMEOUT_EN
      tmo_q   <= tmo_nxt;
`endif
    end
  end

  // Pad enable is gated by rst so the bus is released without waiting for a clock edge.
  assign d_oe     = doe_q & ~rst;
  assign d_out    = dout_q;
  assign rd_req   = req_q;
  assign rd_adr   = adr_q;
  assign rd_count = cnt_q;
`ifdef FSMC_READ_TIMEOUT_EN
  assign rd_err   = err_q;
`else
  assign rd_err   = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_fsmc_read_slave.sv
module tb_fsmc_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        aNE, aNOE, aNWE;
  logic [1:0]  aA;
  logic [15:0] d_out;
  logic        d_oe;
  logic        rd_req;
  logic [1:0]  rd_adr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [7:0]  rd_count;
  logic        rd_err;

  fsmc_read_slave #(.AW(2), .DW(16), .TIMEOUT(15), .TIMEOUT_DATA(16'hDEAD)) dut (
    .clk(clk), .rst(rst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aA(aA),
    .d_out(d_out), .d_oe(d_oe), .rd_req(rd_req), .rd_adr(rd_adr),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_count(rd_count), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register-source model: acks ack_dly cycles after the cycle in which rd_req is first seen.
  int          ack_dly  = 0;
  bit          src_en   = 1'b1;
  logic [15:0] src_data = 16'h0;
  bit          src_inc  = 1'b0;

  initial begin
    rd_ack  = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rd_req && src_en) begin
        repeat (ack_dly) @(negedge clk);
        rd_data = src_data;
        rd_ack  = 1'b1;
        @(negedge clk);
        rd_ack  = 1'b0;
        if (src_inc) src_data = src_data + 16'd1;
        for (int n = 0; n < 100 && rd_req; n++) @(negedge clk);
      end
    end
  end

  int req_rises = 0;
  bit req_prev  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req && !req_prev) req_rises++;
      req_prev = rd_req;
    end
  end

  // One bus read: strobe low for noe_len cycles, then release and let the slave settle.
  task automatic run_read(input logic [1:0] adr, input int noe_len,
                          output bit drove, output int lat, output logic [15:0] dval,
                          output bit stable, output logic [1:0] adr_seen, output int rel,
                          output bit tmo);
    bit got_adr;
    drove = 1'b0; lat = -1; dval = 16'h0; stable = 1'b1; adr_seen = 2'b00;
    rel = -1; tmo = 1'b0; got_adr = 1'b0;
    aA = adr; aNWE = 1'b1; aNE = 1'b0; aNOE = 1'b0;
    for (int i = 1; i <= noe_len; i++) begin
      step();
      if (rd_req && !got_adr) begin adr_seen = rd_adr; got_adr = 1'b1; end
      if (d_oe) begin
        if (!drove) begin drove = 1'b1; lat = i; dval = d_out; end
        else if (d_out !== dval) stable = 1'b0;
      end
    end
    aNOE = 1'b1; aNE = 1'b1;
    if (drove) begin
      for (int i = 1; i <= 20 && rel < 0; i++) begin
        step();
        if (!d_oe) rel = i;
      end
      if (rel < 0) tmo = 1'b1;
    end
    for (int n = 0; n < 100 && rd_req; n++) begin
      step();
      if (rd_req && !got_adr) begin adr_seen = rd_adr; got_adr = 1'b1; end
      if (d_oe) drove = 1'b1;
    end
    if (rd_req) tmo = 1'b1;
    repeat (5) begin
      step();
      if (d_oe) drove = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0]  adr;
    logic [15:0] data;
    int          dly;
    int          noe_len;
    bit          exp_drive;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    bit          drove, stable, tmo;
    int          lat, rel, bad, exp_cnt;
    logic [15:0] dval;
    logic [1:0]  adr_seen;

    vecs[0] = '{2'b10, 16'h1234, 0, 20, 1'b1};
    vecs[1] = '{2'b01, 16'hABCD, 3, 20, 1'b1};
    vecs[2] = '{2'b11, 16'hFFFF, 0, 10, 1'b1};
    vecs[3] = '{2'b00, 16'h0BAD, 10, 3, 1'b0};   // strobe gone long before the late ack
    vecs[4] = '{2'b10, 16'h5A5A, 0, 20, 1'b1};   // normal read right after the aborted one

    aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aA = 2'b00;
    do_reset();

    check("reset_d_oe", {31'b0, d_oe}, 32'd0);
    check("reset_rd_req", {31'b0, rd_req}, 32'd0);
    check("reset_rd_count", {24'b0, rd_count}, 32'd0);
    check("reset_d_out", {16'b0, d_out}, 32'd0);
    check("reset_rd_err", {31'b0, rd_err}, 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (d_oe || rd_req || rd_count != 8'd0) bad++;
    end
    check("idle_100_cycles_bad", bad, 32'd0);

    // Latency to d_oe in edges after the strobe change: 2 sync + 1 (IDLE->REQ)
    // + (dly + 1) until the ack is sampled in REQ. Release: 2 sync + 1.
    exp_cnt = 0;
    for (int v = 0; v < 5; v++) begin
      ack_dly  = vecs[v].dly;
      src_data = vecs[v].data;
      run_read(vecs[v].adr, vecs[v].noe_len, drove, lat, dval, stable, adr_seen, rel, tmo);
      if (vecs[v].exp_drive) exp_cnt++;
      check($sformatf("v%0d_drove", v), {31'b0, drove}, {31'b0, vecs[v].exp_drive});
      check($sformatf("v%0d_rd_adr", v), {30'b0, adr_seen}, {30'b0, vecs[v].adr});
      check($sformatf("v%0d_rd_count", v), {24'b0, rd_count}, exp_cnt);
      check($sformatf("v%0d_timeout", v), {31'b0, tmo}, 32'd0);
      if (vecs[v].exp_drive) begin
        check($sformatf("v%0d_latency", v), lat, 4 + vecs[v].dly);
        check($sformatf("v%0d_d_out", v), {16'b0, dval}, {16'b0, vecs[v].data});
        check($sformatf("v%0d_stable", v), {31'b0, stable}, 32'd1);
        check($sformatf("v%0d_release", v), rel, 32'd3);
      end
    end

    // Write cycle must never raise a request or drive the pads.
    ack_dly = 0;
    req_rises = 0;
    bad = 0;
    aA = 2'b11; aNE = 1'b0; aNWE = 1'b0; aNOE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d_oe || rd_req) bad++;
    end
    aNE = 1'b1; aNWE = 1'b1;
    repeat (5) step();
    check("write_no_activity", bad, 32'd0);
    check("write_no_req_edge", req_rises, 32'd0);
    check("write_count_kept", {24'b0, rd_count}, exp_cnt);

    // 300 back-to-back reads with incrementing source data.
    do_reset();
    req_rises = 0;
    src_data  = 16'h1000;
    src_inc   = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      run_read(2'(i), 8, drove, lat, dval, stable, adr_seen, rel, tmo);
      if (!drove || !stable || tmo || dval !== 16'(16'h1000 + i) || adr_seen !== 2'(i)) begin
        bad++;
        if (bad < 4) $display("FAIL b2b_read_%0d: data %0h expected %0h", i, dval, 16'(16'h1000 + i));
      end
    end
    src_inc = 1'b0;
    check("b2b_bad_reads", bad, 32'd0);
    check("b2b_rd_count_wrap", {24'b0, rd_count}, 32'd44);
    check("b2b_req_edges", req_rises, 32'd300);

`ifdef FSMC_READ_TIMEOUT_EN
    // No ack: 15 REQ cycles after rd_req appears, the timeout word is driven.
    src_en = 1'b0;
    lat = -1;
    aA = 2'b01; aNWE = 1'b1; aNE = 1'b0; aNOE = 1'b0;
    for (int i = 0; i < 20 && !rd_req; i++) step();
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (d_oe) lat = i;
    end
    check("tmo_cycles", lat, 32'd15);
    check("tmo_d_out", {16'b0, d_out}, 32'h0000DEAD);
    check("tmo_rd_err", {31'b0, rd_err}, 32'd1);
    check("tmo_rd_req_low", {31'b0, rd_req}, 32'd0);
    aNOE = 1'b1; aNE = 1'b1;
    repeat (8) step();
    check("tmo_rd_err_sticky", {31'b0, rd_err}, 32'd1);
    src_en = 1'b1;
`endif

    // Asynchronous reset while driving.
    do_reset();
    ack_dly  = 0;
    src_data = 16'hC0DE;
    aA = 2'b10; aNWE = 1'b1; aNE = 1'b0; aNOE = 1'b0;
    for (int i = 0; i < 20 && !d_oe; i++) step();
    check("rstdrv_d_oe_before", {31'b0, d_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstdrv_d_oe_async", {31'b0, d_oe}, 32'd0);
    aNOE = 1'b1; aNE = 1'b1;
    step();
    check("rstdrv_rd_count", {24'b0, rd_count}, 32'd0);
    check("rstdrv_d_out", {16'b0, d_out}, 32'd0);
    rst = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time %0t limit 2000000", $time);
    $fatal(1, "time limit");
  end

endmodule
